// File: rtl/matmul_out_serializer.sv
// Captures one wide matmul result into a 2-slot ping-pong buffer and streams it out as
// MSB-first beats with last on the final beat. Optional macro: MATMUL_OUT_RELU_EN (ReLU at capture).
module matmul_out_serializer #(
  parameter int WIDTH_OUT     = 16,
  parameter int CHUNK_SIZE    = 4,
  parameter int NUM_CORES_A   = 4,
  parameter int NUM_CORES_B   = 1,
  parameter int TOTAL_MODULES = 2,
  parameter int BEAT_WIDTH    = 64,
  localparam int IN_WIDTH  = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES,
  localparam int NUM_BEATS = IN_WIDTH / BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  in_ready,
  output logic [BEAT_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  overflow,
  output logic                  dbg_state_o
);

  // Handshakes: a beat moves on a rising edge where m_tvalid && m_tready; a word is captured
  // on a rising edge where in_valid && in_ready. Beat data/last hold while m_tvalid && !m_tready.

  localparam int NUM_ELEMS = IN_WIDTH / WIDTH_OUT;
  localparam int BCW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NUM_BEATS - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] slot_q [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [BCW-1:0]      beat_cnt_q, beat_cnt_d;
  logic                overflow_q, overflow_d;
  logic                capture, beat_fire, last_fire;
  logic [IN_WIDTH-1:0] store_word;

  always_comb begin
    store_word = in_data;
`ifdef MATMUL_OUT_RELU_EN
    for (int e = 0; e < NUM_ELEMS; e++) begin
      if (in_data[e*WIDTH_OUT + WIDTH_OUT-1]) store_word[e*WIDTH_OUT +: WIDTH_OUT] = '0;
    end
`endif
  end

  always_comb begin
    in_ready    = (count_q != 2'd2);
    capture     = in_valid && in_ready;
    m_tvalid    = (state_q == S_STREAM);
    m_tlast     = m_tvalid && (beat_cnt_q == LAST_BEAT);
    beat_fire   = m_tvalid && m_tready;
    last_fire   = beat_fire && (beat_cnt_q == LAST_BEAT);
    overflow    = overflow_q;
    dbg_state_o = (state_q == S_STREAM);

    // Beat 0 is the most significant slice of the stored word.
    m_tdata = '0;
    if (m_tvalid) begin
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (beat_cnt_q == BCW'(b)) m_tdata = slot_q[rd_ptr_q][IN_WIDTH-1-b*BEAT_WIDTH -: BEAT_WIDTH];
      end
    end

    wr_ptr_d   = wr_ptr_q ^ capture;
    rd_ptr_d   = rd_ptr_q ^ last_fire;
    beat_cnt_d = beat_cnt_q;
    if (last_fire)      beat_cnt_d = '0;
    else if (beat_fire) beat_cnt_d = beat_cnt_q + BCW'(1);

    count_d = count_q;
    case ({capture, last_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q | (in_valid & ~in_ready);
    state_d    = (count_d == 2'd0) ? S_IDLE : S_STREAM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // A free slot is never the one being read, so capture cannot corrupt the current frame.
  always_ff @(posedge clk) begin
    if (capture) slot_q[wr_ptr_q] <= store_word;
  end

endmodule
